// File: rtl/game_defs.sv
// -----------------------------------------------------------------------------
// game_defs
//   Definitions shared by the game controller front end: the one-hot choice
//   encodings, the capture FSM state encodings, the waitingPlayer codes and
//   the small helpers that decode them.
// -----------------------------------------------------------------------------
package game_defs;

  typedef logic [2:0] choice_t;

  localparam choice_t CAT     = 3'b001;
  localparam choice_t DOG     = 3'b010;
  localparam choice_t CHICKEN = 3'b100;
  localparam choice_t NO_CHOICE = 3'b000;

  localparam logic [1:0] P1_WAIT = 2'd0;
  localparam logic [1:0] P2_WAIT = 2'd1;
  localparam logic [1:0] READY   = 2'd2;

  localparam logic [1:0] WAITING_P1   = 2'b01;
  localparam logic [1:0] WAITING_P2   = 2'b10;
  localparam logic [1:0] WAITING_NONE = 2'b00;

  // Exactly one of the three switches up; 000 and multi-hot are rejected.
  function automatic logic is_onehot3(input choice_t v);
    return (v == CAT) || (v == DOG) || (v == CHICKEN);
  endfunction

  function automatic logic [1:0] waiting_code(input logic [1:0] st);
    logic [1:0] code;
    case (st)
      P1_WAIT: code = WAITING_P1;
      P2_WAIT: code = WAITING_P2;
      default: code = WAITING_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions a raw active-low push key that is asynchronous to clk.
//   2-FF synchroniser -> stability down-counter -> debounced level -> one-cycle
//   pulse on the released->pressed transition. Releases produce no pulse.
//   Raw edge to press_pulse latency is 2 + DEBOUNCE_CYCLES cycles.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive equal synchronised samples needed to accept
//                    a new level (>= 1)
// Ports
//   clk            in  system clock
//   stateReset     in  synchronous active-high reset (returns to "released")
//   key_n          in  raw key, active-low
//   pressed_level  out debounced level, 1 = pressed
//   press_pulse    out one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic stateReset,
  input  logic key_n,
  output logic pressed_level,
  output logic press_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_n;
  logic          sync2_n;
  logic [CW-1:0] stable_cnt;
  logic          sample_pressed;
  logic          differs;

  assign sample_pressed = ~sync2_n;
  assign differs        = (sample_pressed != pressed_level);

  // The counter reloads whenever the sample agrees with the accepted level, so
  // it only reaches zero after DEBOUNCE_CYCLES back-to-back disagreeing samples.
  always_ff @(posedge clk) begin
    if (stateReset) begin
      sync1_n       <= 1'b1;
      sync2_n       <= 1'b1;
      stable_cnt    <= RELOAD;
      pressed_level <= 1'b0;
      press_pulse   <= 1'b0;
    end else begin
      sync1_n     <= key_n;
      sync2_n     <= sync1_n;
      press_pulse <= 1'b0;
      if (!differs) begin
        stable_cnt <= RELOAD;
      end else if (stable_cnt == '0) begin
        pressed_level <= sample_pressed;
        press_pulse   <= sample_pressed;
        stable_cnt    <= RELOAD;
      end else begin
        stable_cnt <= stable_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/choice_capture.sv
// -----------------------------------------------------------------------------
// choice_capture
//   Collects the two player choices in turn from the shared switches. Each
//   choice is committed by a debounced confirm press with a one-hot sw value.
//   Both choices are then presented with choicesValid, held until ack.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   P1_WAIT | waiting for player 1 to confirm a one-hot choice
//   P2_WAIT | player 1 committed, waiting for player 2
//   READY   | both committed, choicesValid high until ack
//
// Parameters
//   DEBOUNCE_CYCLES  confirm key stability requirement in cycles
//   TIMEOUT_CYCLES   per-player timeout (only used with CHOICE_TIMEOUT_EN)
// Build option
//   CHOICE_TIMEOUT_EN  when defined, a waiting player is auto-committed as CAT
//                      after TIMEOUT_CYCLES cycles without a valid press.
// Ports
//   clk            in   system clock
//   stateReset     in   synchronous active-high reset
//   sw[2:0]        in   raw choice switches (cat=001 dog=010 chicken=100)
//   confirm_n      in   raw confirm key, active-low, asynchronous
//   ack            in   controller has consumed the choices
//   player1Choice  out  committed player-1 choice
//   player2Choice  out  committed player-2 choice
//   choicesValid   out  both choices committed, held until ack
//   waitingPlayer  out  01 = P1, 10 = P2, 00 = ready
//   invalidPulse   out  one-cycle pulse: confirm with non-one-hot sw
// -----------------------------------------------------------------------------
module choice_capture
  import game_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       stateReset,
  input  logic [2:0] sw,
  input  logic       confirm_n,
  input  logic       ack,
  output logic [2:0] player1Choice,
  output logic [2:0] player2Choice,
  output logic       choicesValid,
  output logic [1:0] waitingPlayer,
  output logic       invalidPulse
);

  if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("choice_capture: needs DEBOUNCE_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
  end

  logic       press;
  logic       key_level_unused;  // debounced level is not needed, only its edge
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       commit_p1;
  logic       commit_p2;
  choice_t    commit_val;
  logic       invalid_nxt;
  logic       timeout_hit;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clk          (clk),
    .stateReset   (stateReset),
    .key_n        (confirm_n),
    .pressed_level(key_level_unused),
    .press_pulse  (press)
  );

`ifdef CHOICE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  assign timeout_hit = (state != READY) && (tmo_cnt == '0);

  // Restart on any state change so each player gets a full window.
  always_ff @(posedge clk) begin
    if (stateReset || (state_nxt != state) || (state == READY)) begin
      tmo_cnt <= TMO_RELOAD;
    end else begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    commit_p1   = 1'b0;
    commit_p2   = 1'b0;
    commit_val  = sw;
    invalid_nxt = 1'b0;
    case (state)
      P1_WAIT, P2_WAIT: begin
        // A valid press beats a simultaneous timeout; an invalid one still
        // reports itself but lets the timeout commit go ahead.
        if (press && is_onehot3(sw)) begin
          commit_p1 = (state == P1_WAIT);
          commit_p2 = (state == P2_WAIT);
        end else begin
          invalid_nxt = press;
          if (timeout_hit) begin
            commit_val = CAT;
            commit_p1  = (state == P1_WAIT);
            commit_p2  = (state == P2_WAIT);
          end
        end
        if (commit_p1) state_nxt = P2_WAIT;
        if (commit_p2) state_nxt = READY;
      end
      READY: begin
        // Presses are ignored here, including one coinciding with ack.
        if (ack) state_nxt = P1_WAIT;
      end
      default: state_nxt = P1_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (stateReset) begin
      state         <= P1_WAIT;
      player1Choice <= NO_CHOICE;
      player2Choice <= NO_CHOICE;
      choicesValid  <= 1'b0;
      waitingPlayer <= WAITING_P1;
      invalidPulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      invalidPulse  <= invalid_nxt;
      choicesValid  <= (state_nxt == READY);
      waitingPlayer <= waiting_code(state_nxt);
      if (commit_p1) player1Choice <= commit_val;
      if (commit_p2) player2Choice <= commit_val;
    end
  end

endmodule

// File: tb/tb_choice_capture.sv
// -----------------------------------------------------------------------------
// tb_choice_capture
//   Randomised and directed stimulus against a cycle-level reference model.
//   The model derives key presses from a sample-history window ("the last D
//   synchronised samples all disagree with the accepted level") and applies
//   the capture rules on whole-round terms (which player is waiting).
// -----------------------------------------------------------------------------
module tb_choice_capture;

  localparam int D = 4;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       stateReset;
  logic [2:0] sw;
  logic       confirm_n;
  logic       ack;
  logic [2:0] player1Choice;
  logic [2:0] player2Choice;
  logic       choicesValid;
  logic [1:0] waitingPlayer;
  logic       invalidPulse;

  always #5 clk = ~clk;

  choice_capture #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .stateReset   (stateReset),
    .sw           (sw),
    .confirm_n    (confirm_n),
    .ack          (ack),
    .player1Choice(player1Choice),
    .player2Choice(player2Choice),
    .choicesValid (choicesValid),
    .waitingPlayer(waitingPlayer),
    .invalidPulse (invalidPulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         hist [0:D];   // hist[0] = most recent raw sample
  bit         m_level;      // debounced "pressed"
  bit         m_press;      // press pulse visible this cycle
  int         m_wait;       // 1 = P1 waiting, 2 = P2 waiting, 0 = ready
  logic [2:0] m_p1, m_p2;
  bit         m_valid, m_inv;
  int         m_tcnt;
  int         inv_seen = 0;

  task automatic model_reset();
    for (int i = 0; i <= D; i++) hist[i] = 1'b1;
    m_level = 0; m_press = 0; m_wait = 1;
    m_p1 = 3'b000; m_p2 = 3'b000; m_valid = 0; m_inv = 0; m_tcnt = 0;
  endtask

  task automatic model_edge();
    bit         flip;
    bit         committed;
    logic [2:0] val;
    if (stateReset) begin
      model_reset();
      return;
    end
    m_inv = 0;
    committed = 0;
    val = sw;
    if (m_wait != 0) begin
      if (m_press && $countones(sw) == 1) committed = 1;
      else begin
        if (m_press) m_inv = 1;
`ifdef CHOICE_TIMEOUT_EN
        if (m_tcnt == T - 1) begin
          committed = 1;
          val = 3'b001;
        end
`endif
      end
      if (committed) begin
        if (m_wait == 1) begin m_p1 = val; m_wait = 2; end
        else begin m_p2 = val; m_wait = 0; m_valid = 1; end
        m_tcnt = 0;
      end else begin
        m_tcnt++;
      end
    end else if (ack) begin
      m_wait = 1; m_valid = 0; m_tcnt = 0;
    end
    // the synchroniser adds two samples of delay: the window is hist[1..D]
    flip = 1;
    for (int i = 1; i <= D; i++) if ((hist[i] == 1'b0) == m_level) flip = 0;
    m_press = 0;
    if (flip) begin
      m_level = !m_level;
      m_press = m_level;
    end
    for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
    hist[0] = confirm_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("p1", player1Choice, m_p1);
    check_eq("p2", player2Choice, m_p2);
    check_eq("valid", choicesValid, m_valid);
    check_eq("waiting", waitingPlayer, m_wait[1:0]);
    check_eq("invalid", invalidPulse, m_inv);
    if (invalidPulse === 1'b1) inv_seen++;
  endtask

  task automatic do_reset();
    stateReset = 1'b1;
    step();
    stateReset = 1'b0;
  endtask

  task automatic press_key(input logic [2:0] s, input int hold, input int gap);
    sw = s;
    confirm_n = 1'b0;
    repeat (hold) step();
    confirm_n = 1'b1;
    repeat (gap) step();
  endtask

`ifdef CHOICE_TIMEOUT_EN
  localparam int HOLD = 40;
`else
  localparam int HOLD = 100;
`endif

  initial begin
    int n;
    int inv0;
    int run;
    stateReset = 1'b1; confirm_n = 1'b1; sw = 3'b000; ack = 1'b0;
    model_reset();

    // reset state
    do_reset();
    check_eq("rst_p1", player1Choice, 3'b000);
    check_eq("rst_wait", waitingPlayer, 2'b01);
    check_eq("rst_valid", choicesValid, 1'b0);
    check_eq("rst_inv", invalidPulse, 1'b0);

    // invalid choices right after reset
    inv0 = inv_seen;
    press_key(3'b011, 8, 8);
    check_eq("inv011_cnt", inv_seen - inv0, 1);
    check_eq("inv011_wait", waitingPlayer, 2'b01);
    check_eq("inv011_p1", player1Choice, 3'b000);
    inv0 = inv_seen;
    press_key(3'b000, 8, 8);
    check_eq("inv000_cnt", inv_seen - inv0, 1);
    check_eq("inv000_wait", waitingPlayer, 2'b01);

    // normal round
    do_reset();
    press_key(3'b010, 8, 8);
    press_key(3'b100, 8, 8);
    check_eq("rnd_p1", player1Choice, 3'b010);
    check_eq("rnd_p2", player2Choice, 3'b100);
    check_eq("rnd_valid", choicesValid, 1'b1);
    check_eq("rnd_wait", waitingPlayer, 2'b00);
    ack = 1'b1; step(); ack = 1'b0;
    check_eq("ack_valid", choicesValid, 1'b0);
    check_eq("ack_wait", waitingPlayer, 2'b01);

    // bounce: toggling every 2 cycles, then held low
    sw = 3'b001;
    for (int i = 0; i < 10; i++) begin
      confirm_n = ~confirm_n;
      repeat (2) step();
    end
    confirm_n = 1'b0;
    n = 0;
    while (player1Choice !== 3'b001 && n < 30) begin
      step();
      n++;
    end
    // press pulse 6 cycles after the edge, committed choice visible one later
    check_eq("bounce_latency", n, 7);
    check_eq("bounce_wait", waitingPlayer, 2'b10);
    confirm_n = 1'b1;
    repeat (8) step();

    // held key, presses in READY, press/ack collision
    do_reset();
    sw = 3'b010;
    confirm_n = 1'b0;
    repeat (HOLD) step();
    check_eq("held_wait", waitingPlayer, 2'b10);
    check_eq("held_p1", player1Choice, 3'b010);
    confirm_n = 1'b1;
    repeat (8) step();
    press_key(3'b100, 8, 8);
    check_eq("ready_valid", choicesValid, 1'b1);
    inv0 = inv_seen;
    press_key(3'b001, 8, 8);
    check_eq("ready_p1", player1Choice, 3'b010);
    check_eq("ready_p2", player2Choice, 3'b100);
    check_eq("ready_wait", waitingPlayer, 2'b00);
    check_eq("ready_inv", inv_seen - inv0, 0);
    sw = 3'b001;
    confirm_n = 1'b0;
    repeat (6) step();
    ack = 1'b1; step(); ack = 1'b0;
    check_eq("coll_wait", waitingPlayer, 2'b01);
    check_eq("coll_valid", choicesValid, 1'b0);
    repeat (4) step();
    confirm_n = 1'b1;
    repeat (8) step();
    check_eq("coll_nocommit_wait", waitingPlayer, 2'b01);
    check_eq("coll_nocommit_p1", player1Choice, 3'b010);

    // reset mid-round
    do_reset();
    press_key(3'b100, 8, 2);
    check_eq("mid_p1", player1Choice, 3'b100);
    do_reset();
    check_eq("mid_rst_p1", player1Choice, 3'b000);
    check_eq("mid_rst_wait", waitingPlayer, 2'b01);
    check_eq("mid_rst_valid", choicesValid, 1'b0);
    repeat (8) step();

`ifdef CHOICE_TIMEOUT_EN
    do_reset();
    sw = 3'b010;
    repeat (T - 1) step();
    check_eq("tmo_before_p1", player1Choice, 3'b000);
    step();
    check_eq("tmo_p1", player1Choice, 3'b001);
    check_eq("tmo_wait", waitingPlayer, 2'b10);
    do_reset();
    repeat (T - 7) step();
    sw = 3'b100;
    confirm_n = 1'b0;
    repeat (7) step();
    check_eq("tmo_press_p1", player1Choice, 3'b100);
    confirm_n = 1'b1;
    repeat (8) step();
`endif

    // randomised traffic checked cycle by cycle against the model
    do_reset();
    run = 1;
    for (int c = 0; c < 2500; c++) begin
      run--;
      if (run <= 0) begin
        confirm_n = ~confirm_n;
        run = $urandom_range(10, 1);
      end
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(9, 0) < 6) sw = 3'b001 << $urandom_range(2, 0);
        else sw = 3'($urandom_range(7, 0));
      end
      ack = ($urandom_range(5, 0) == 0);
      stateReset = ($urandom_range(199, 0) == 0);
      step();
    end
    stateReset = 1'b0; ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
